// File: rtl/i2c_reg_bridge_pkg.sv
// rtl/i2c_reg_bridge_pkg.sv - shared types and default sizes for the I2C register bridge
package i2c_reg_bridge_pkg;

    typedef enum logic [1:0] {BR_IDLE, BR_GET_PTR, BR_WRITE, BR_READ} bridge_state_t;

    localparam int I2C_REG_COUNT = 32;
    localparam int I2C_RO_BASE   = 16;

endpackage

// File: rtl/reg_file_2w2r.sv
// rtl/reg_file_2w2r.sv - NUM_REGS x 8 register file, two write ports (A wins), two registered read ports
module reg_file_2w2r #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    input  logic              a_re,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [7:0]        a_rdata,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic [7:0]        b_rdata,
    output logic              collide
);

    logic [7:0] regs [NUM_REGS];
    logic       same_idx;

    assign same_idx = a_we && b_we && (a_addr == b_addr);

    // Reads sample before this cycle's writes land, so a same-cycle write returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            a_rdata <= 8'h00;
            b_rdata <= 8'h00;
            collide <= 1'b0;
        end else begin
            if (b_we && !same_idx) regs[b_addr] <= b_wdata;
            if (a_we)              regs[a_addr] <= a_wdata;
            if (a_re)              a_rdata      <= regs[a_raddr];
            b_rdata <= regs[b_raddr];
            collide <= same_idx;
        end
    end

endmodule

// File: rtl/i2c_reg_bridge.sv
// rtl/i2c_reg_bridge.sv - turns I2C slave byte events into pointer-addressed register file accesses
module i2c_reg_bridge
    import i2c_reg_bridge_pkg::*;
#(
    parameter  int NUM_REGS = I2C_REG_COUNT,
    parameter  int RO_BASE  = I2C_RO_BASE,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              i2c_start,
    input  logic              i2c_rw,
    input  logic              i2c_stop,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_req,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic [ADDR_W-1:0] fab_addr,
    input  logic [7:0]        fab_wdata,
    input  logic              fab_we,
    output logic [7:0]        fab_rdata,
    output logic              wr_commit,
    output logic              wr_collide
);

    bridge_state_t     state;
    logic [ADDR_W-1:0] ptr;
    logic              written;
    logic              quiet;
    logic              ptr_writable;
    logic              i2c_we;
    logic              rd_en;

    // Byte events coinciding with a START or STOP belong to no data phase and are ignored.
    assign quiet        = !i2c_start && !i2c_stop;
    assign ptr_writable = int'(ptr) < RO_BASE;
    assign i2c_we       = (state == BR_WRITE) && rx_valid && quiet && ptr_writable;
    assign rd_en        = (state == BR_READ) && tx_req && quiet;

    reg_file_2w2r #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_regs (
        .clk     (sclk),
        .rst     (rst),
        .a_we    (i2c_we),
        .a_addr  (ptr),
        .a_wdata (rx_data),
        .b_we    (fab_we),
        .b_addr  (fab_addr),
        .b_wdata (fab_wdata),
        .a_re    (rd_en),
        .a_raddr (ptr),
        .a_rdata (tx_data),
        .b_raddr (fab_addr),
        .b_rdata (fab_rdata),
        .collide (wr_collide)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= BR_IDLE;
            ptr       <= '0;
            written   <= 1'b0;
            tx_valid  <= 1'b0;
            wr_commit <= 1'b0;
        end else begin
            tx_valid  <= rd_en;
            wr_commit <= 1'b0;
            if (quiet) begin
                case (state)
                    BR_GET_PTR: if (rx_valid) begin
                        ptr   <= rx_data[ADDR_W-1:0];
                        state <= BR_WRITE;
                    end
                    BR_WRITE: if (rx_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr_writable) written <= 1'b1;
                    end
                    BR_READ: if (tx_req) ptr <= ptr + ADDR_W'(1);
                    default: ;
                endcase
            end
            // STOP is handled before START so a merged STOP/START still commits.
            if (i2c_stop) begin
                state     <= BR_IDLE;
                wr_commit <= written;
                written   <= 1'b0;
            end
            if (i2c_start) state <= i2c_rw ? BR_READ : BR_GET_PTR;
        end
    end

endmodule
